register_file_scoreboard: RTL and testbench

- Parametrised successor to the 32x32 two-read/one-write register memory. It serves as the integer register file for the core pipeline.
- Adds a configurable register width, register count and number of read ports, plus an asynchronous clear.
- Adds a per-register busy scoreboard. Issue logic sets a register's busy bit; writeback clears it. Decode stalls on busy sources.
- Sits between decode (read and issue) and writeback (write and busy clear).

---
 rtl/register_file_scoreboard.sv | 99 +++++++++
 tb/tb_register_file_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Integer register file for the core pipeline with a per-register busy
//   scoreboard. Decode reads operands and issues destinations (setting
//   busy); writeback writes results (clearing busy). Register 0 reads as
//   zero, is never busy, and ignores writes and issues.
//
// Parameters
//   XLEN  : register width
//   NREGS : register count (power of two, >= 2)
//   NRD   : number of combinational read ports (1..4)
//   AW    : address width, derived from NREGS
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   rd_address   : NRD flattened read addresses, port k at [k*AW +: AW]
//   data_out     : NRD flattened read data, port k at [k*XLEN +: XLEN]
//   busy_out     : busy bit of the register addressed by each read port
//   wr_enable, wr_address, wr_data : writeback (write + busy clear)
//   iss_enable, iss_address        : issue (busy set)
//   busy_vec     : full scoreboard, bit i = register i busy
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a same-cycle writeback to a read
//   port's address is forwarded to data_out and clears busy_out, unless
//   the same register is being re-issued in that cycle.
module register_file_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_address,
  output logic [NRD*XLEN-1:0] data_out,
  output logic [NRD-1:0]      busy_out,
  input  logic                wr_enable,
  input  logic [AW-1:0]       wr_address,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_enable,
  input  logic [AW-1:0]       iss_address,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // One-hot issue/writeback decode; register 0 masked out of both.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_enable) set_vec[iss_address] = 1'b1;
    if (wr_enable)  clr_vec[wr_address]  = 1'b1;
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
  end

  // Set is applied after clear so a same-edge issue wins over writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_enable && (wr_address != '0)) begin
      mem[wr_address] <= wr_data;
    end
  end

  assign busy_vec = busy;

  always_comb begin
    logic [AW-1:0] ra;
    ra       = '0;
    data_out = '0;
    busy_out = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = rd_address[k*AW +: AW];
      data_out[k*XLEN +: XLEN] = (ra == '0) ? '0 : mem[ra];
      busy_out[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by rst_n so reset forces zero outputs even
      // while a writeback strobe is present.
      if (rst_n && wr_enable && (wr_address != '0) && (wr_address == ra)) begin
        data_out[k*XLEN +: XLEN] = wr_data;
        if (!(iss_enable && (iss_address == wr_address))) busy_out[k] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard
//   Directed bench for register_file_scoreboard (default parameters).
//   Expected values are queued when stimulus is applied and popped and
//   compared against the DUT outputs when they are sampled.
module tb_register_file_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_address;
  logic [NRD*XLEN-1:0] data_out;
  logic [NRD-1:0]      busy_out;
  logic                wr_enable;
  logic [AW-1:0]       wr_address;
  logic [XLEN-1:0]     wr_data;
  logic                iss_enable;
  logic [AW-1:0]       iss_address;
  logic [NREGS-1:0]    busy_vec;

  register_file_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_address  (rd_address),
    .data_out    (data_out),
    .busy_out    (busy_out),
    .wr_enable   (wr_enable),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .iss_enable  (iss_enable),
    .iss_address (iss_address),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = data_out[idx], 1 = busy_out[idx], 2 = busy_vec
  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  // Compare every queued expectation against the current DUT outputs.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       obs = data_out[e.idx*XLEN +: XLEN];
        1:       obs = {31'b0, busy_out[e.idx]};
        default: obs = busy_vec;
      endcase
      total++;
      assert (obs === e.exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_address = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; rd_address = '0; wr_enable = 1'b0; wr_address = '0;
    wr_data = '0; iss_enable = 1'b0; iss_address = '0;

    // 1. reset then read
    set_rd(5'd0, 5'hA);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    push("rst_d0", 0, 0, 32'h0);
    push("rst_d1", 0, 1, 32'h0);
    push("rst_bv", 2, 0, 32'h0);
    check_all();
    tick();

    // 2. write and read
    wr_enable = 1'b1; wr_address = 5'hA; wr_data = 32'hABCDEFAB;
    set_rd(5'hA, 5'hA);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("wr_cyc_d0", 0, 0, 32'hABCDEFAB);
    push("wr_cyc_d1", 0, 1, 32'hABCDEFAB);
`else
    push("wr_cyc_d0", 0, 0, 32'h0);
    push("wr_cyc_d1", 0, 1, 32'h0);
`endif
    check_all();
    tick();
    wr_enable = 1'b0;
    #1;
    push("wr_d0", 0, 0, 32'hABCDEFAB);
    push("wr_d1", 0, 1, 32'hABCDEFAB);
    check_all();

    // 3. register 0 immutable
    wr_enable = 1'b1; wr_address = 5'd0; wr_data = 32'hEEEEEEEE;
    iss_enable = 1'b1; iss_address = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    push("r0_cyc_d0", 0, 0, 32'h0);
    check_all();
    tick();
    wr_enable = 1'b0; iss_enable = 1'b0;
    #1;
    push("r0_d0", 0, 0, 32'h0);
    push("r0_d1", 0, 1, 32'h0);
    push("r0_bv", 2, 0, 32'h0);
    push("r0_bo", 1, 0, 32'h0);
    check_all();

    // 4. scoreboard set then clear on register 5
    iss_enable = 1'b1; iss_address = 5'd5;
    set_rd(5'd5, 5'hA);
    #1;
    push("iss_cyc_bo", 1, 0, 32'h0);
    push("iss_cyc_bv", 2, 0, 32'h0);
    check_all();
    tick();
    iss_enable = 1'b0;
    #1;
    push("iss_bv", 2, 0, 32'h20);
    push("iss_bo0", 1, 0, 32'h1);
    push("iss_bo1", 1, 1, 32'h0);
    check_all();
    wr_enable = 1'b1; wr_address = 5'd5; wr_data = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    push("wb_cyc_bo", 1, 0, 32'h0);
    push("wb_cyc_d0", 0, 0, 32'h12345678);
`else
    push("wb_cyc_bo", 1, 0, 32'h1);
    push("wb_cyc_d0", 0, 0, 32'h0);
`endif
    push("wb_cyc_bv", 2, 0, 32'h20);
    check_all();
    tick();
    wr_enable = 1'b0;
    #1;
    push("wb_bv", 2, 0, 32'h0);
    push("wb_d0", 0, 0, 32'h12345678);
    push("wb_bo0", 1, 0, 32'h0);
    check_all();

    // 5. simultaneous issue and writeback on register 7: set wins
    wr_enable = 1'b1; wr_address = 5'd7; wr_data = 32'h77777777;
    iss_enable = 1'b1; iss_address = 5'd7;
    set_rd(5'd7, 5'd7);
    tick();
    wr_enable = 1'b0; iss_enable = 1'b0;
    #1;
    push("sim_bv", 2, 0, 32'h80);
    push("sim_d0", 0, 0, 32'h77777777);
    push("sim_bo1", 1, 1, 32'h1);
    check_all();
    // re-issue while busy stays busy; writeback to idle reg 3 leaves it clear
    iss_enable = 1'b1; iss_address = 5'd7;
    wr_enable = 1'b1; wr_address = 5'd3; wr_data = 32'h33333333;
    tick();
    iss_enable = 1'b0; wr_enable = 1'b0;
    set_rd(5'd3, 5'd7);
    #1;
    push("reiss_bv", 2, 0, 32'h80);
    push("idle_wb_d0", 0, 0, 32'h33333333);
    check_all();
    wr_enable = 1'b1; wr_address = 5'd7; wr_data = 32'h70707070;
    tick();
    wr_enable = 1'b0;
    #1;
    push("clr7_bv", 2, 0, 32'h0);
    push("clr7_d1", 0, 1, 32'h70707070);
    check_all();

    // address-decode sweep: fill 1..31, read back on both ports crosswise
    for (int i = 1; i < NREGS; i++) begin
      wr_enable = 1'b1; wr_address = AW'(i); wr_data = 32'h5A000000 ^ (i * 32'h00010203);
      tick();
    end
    wr_enable = 1'b0;
    for (int i = 0; i < NREGS; i += 5) begin
      set_rd(AW'(i), AW'(NREGS - 1 - i));
      #1;
      v = (i == 0) ? 32'h0 : (32'h5A000000 ^ (i * 32'h00010203));
      push($sformatf("sweep_p0_r%0d", i), 0, 0, v);
      push($sformatf("sweep_p1_r%0d", NREGS - 1 - i), 0, 1,
           32'h5A000000 ^ ((NREGS - 1 - i) * 32'h00010203));
      check_all();
    end

    // 6. asynchronous reset mid-operation
    wr_enable = 1'b1; wr_address = 5'd3; wr_data = 32'h03030303;
    tick();
    wr_address = 5'd9; wr_data = 32'h09090909;
    iss_enable = 1'b1; iss_address = 5'd9;
    tick();
    wr_enable = 1'b0; iss_enable = 1'b0;
    set_rd(5'd3, 5'd9);
    #1;
    push("pre_rst_d0", 0, 0, 32'h03030303);
    push("pre_rst_d1", 0, 1, 32'h09090909);
    push("pre_rst_bv", 2, 0, 32'h200);
    check_all();
    rst_n = 1'b0;
    #1;
    push("arst_d0", 0, 0, 32'h0);
    push("arst_d1", 0, 1, 32'h0);
    push("arst_bv", 2, 0, 32'h0);
    push("arst_bo1", 1, 1, 32'h0);
    check_all();
    tick();
    rst_n = 1'b1;
    #1;
    push("post_rst_d1", 0, 1, 32'h0);
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
